// File: rtl/fetch_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_gen
// Brief    : Front-end PC generator / instruction-bus requester with
//            in-flight PC FIFO, redirect kill and per-slot valid masks.
//            Optional FETCH_PERF_CNT_EN adds perf_killed / perf_stall.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_pc_gen #(
    parameter int          FETCH_WIDTH     = 2,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'hbfc00000
) (
    input  logic                      clk,
    input  logic                      resetn,
    output logic                      ireq_valid,
    output logic [31:0]               ireq_addr,
    input  logic                      ireq_addr_ok,
    input  logic                      iresp_data_ok,
    input  logic [32*FETCH_WIDTH-1:0] iresp_data,
    input  logic                      exc_valid,
    input  logic [31:0]               exc_vec,
    input  logic                      eret,
    input  logic [31:0]               epc,
    input  logic                      bp_fail,
    input  logic [31:0]               pc_not_taken,
    input  logic                      pred_taken,
    input  logic [31:0]               pred_target,
    input  logic                      queue_full,
    output logic                      out_valid,
    output logic [31:0]               out_pc,
    output logic [32*FETCH_WIDTH-1:0] out_data,
    output logic [FETCH_WIDTH-1:0]    out_mask,
    output logic                      out_adel
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]               perf_killed,
    output logic [31:0]               perf_stall
`endif
);

    localparam int                 c_GROUP_BYTES = 4 * FETCH_WIDTH;
    localparam logic [31:0]        c_OFF_MASK    = 32'(c_GROUP_BYTES - 1);
    localparam int                 c_PTR_W       = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int                 c_CNT_W       = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [c_CNT_W-1:0] c_MAX_CNT     = c_CNT_W'(MAX_OUTSTANDING);

    logic [31:0]               r_cur_pc;
    logic [c_CNT_W-1:0]        r_outstanding;
    logic [c_CNT_W-1:0]        r_kill_cnt;
    logic                      r_halted;
    logic [31:0]               r_fifo [MAX_OUTSTANDING];
    logic [c_PTR_W-1:0]        r_wr_ptr;
    logic [c_PTR_W-1:0]        r_rd_ptr;
    logic                      r_out_valid;
    logic [31:0]               r_out_pc;
    logic [32*FETCH_WIDTH-1:0] r_out_data;
    logic [FETCH_WIDTH-1:0]    r_out_mask;
    logic                      r_out_adel;

    logic                      w_redirect;
    logic [31:0]               w_redirect_pc;
    logic                      w_misaligned;
    logic                      w_ireq_valid;
    logic                      w_accept;
    logic                      w_resp;
    logic                      w_deliver;
    logic                      w_discard;
    logic                      w_adel_emit;
    logic [31:0]               w_pop_pc;
    logic [31:0]               w_pop_slot;
    logic [31:0]               w_seq_pc;
    logic [FETCH_WIDTH-1:0]    w_mask;

    function automatic logic [c_PTR_W-1:0] f_next_ptr(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_redirect    = exc_valid | eret | bp_fail;
    assign w_redirect_pc = exc_valid ? exc_vec : (eret ? epc : pc_not_taken);
    assign w_misaligned  = (r_cur_pc[1:0] != 2'b00);
    // Gating with resetn keeps the request low while reset is held.
    assign w_ireq_valid  = resetn && !w_redirect && !queue_full && !r_halted &&
                           !w_misaligned && (r_outstanding < c_MAX_CNT);
    assign w_accept      = w_ireq_valid && ireq_addr_ok;
    assign w_resp        = iresp_data_ok && (r_outstanding != '0);
    assign w_deliver     = w_resp && !w_redirect && (r_kill_cnt == '0);
    assign w_discard     = w_resp && !w_deliver;
    assign w_adel_emit   = w_misaligned && !w_redirect && !r_halted && (r_outstanding == '0);
    assign w_pop_pc      = r_fifo[r_rd_ptr];
    assign w_pop_slot    = (w_pop_pc & c_OFF_MASK) >> 2;
    assign w_seq_pc      = (r_cur_pc & ~c_OFF_MASK) + 32'(c_GROUP_BYTES);

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            w_mask[i] = (32'(i) >= w_pop_slot);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cur_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_kill_cnt    <= '0;
            r_halted      <= 1'b0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else begin
            if (w_redirect) begin
                r_cur_pc <= w_redirect_pc;
            end else if (w_accept) begin
                r_cur_pc <= pred_taken ? pred_target : w_seq_pc;
            end
            r_outstanding <= r_outstanding + c_CNT_W'(w_accept) - c_CNT_W'(w_resp);
            // Everything still in flight after this cycle's response belongs to the old path.
            if (w_redirect) begin
                r_kill_cnt <= r_outstanding - c_CNT_W'(w_resp);
            end else if (w_resp && (r_kill_cnt != '0)) begin
                r_kill_cnt <= r_kill_cnt - 1'b1;
            end
            if (w_redirect) begin
                r_halted <= 1'b0;
            end else if (w_adel_emit) begin
                r_halted <= 1'b1;
            end
            if (w_accept) begin
                r_wr_ptr <= f_next_ptr(r_wr_ptr);
            end
            if (w_resp) begin
                r_rd_ptr <= f_next_ptr(r_rd_ptr);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_fifo[r_wr_ptr] <= r_cur_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_out_valid <= 1'b0;
            r_out_pc    <= '0;
            r_out_data  <= '0;
            r_out_mask  <= '0;
            r_out_adel  <= 1'b0;
        end else begin
            r_out_valid <= w_deliver | w_adel_emit;
            r_out_pc    <= w_adel_emit ? r_cur_pc : (w_deliver ? (w_pop_pc & ~c_OFF_MASK) : '0);
            r_out_data  <= w_deliver ? iresp_data : '0;
            r_out_mask  <= w_deliver ? w_mask : '0;
            r_out_adel  <= w_adel_emit;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            perf_killed <= '0;
            perf_stall  <= '0;
        end else begin
            if (w_discard && (perf_killed != '1)) begin
                perf_killed <= perf_killed + 1'b1;
            end
            if (!w_ireq_valid && !r_halted && (perf_stall != '1)) begin
                perf_stall <= perf_stall + 1'b1;
            end
        end
    end
`else
    logic w_unused_discard;
    assign w_unused_discard = w_discard;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (resetn) begin
            assert (!(iresp_data_ok && (r_outstanding == '0)))
                else $error("fetch_pc_gen: response with nothing outstanding");
            assert (r_outstanding <= c_MAX_CNT)
                else $error("fetch_pc_gen: outstanding overflow");
        end
    end
`endif

    assign ireq_valid = w_ireq_valid;
    assign ireq_addr  = r_cur_pc & ~c_OFF_MASK;
    assign out_valid  = r_out_valid;
    assign out_pc     = r_out_pc;
    assign out_data   = r_out_data;
    assign out_mask   = r_out_mask;
    assign out_adel   = r_out_adel;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_pc_gen
// Brief    : Directed self-checking bench for fetch_pc_gen with an in-order
//            bus model (one-cycle minimum response latency).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_gen;

    localparam int c_FW = 2;

    logic              clk;
    logic              resetn;
    logic              ireq_valid;
    logic [31:0]       ireq_addr;
    logic              ireq_addr_ok;
    logic              iresp_data_ok;
    logic [32*c_FW-1:0] iresp_data;
    logic              exc_valid;
    logic [31:0]       exc_vec;
    logic              eret;
    logic [31:0]       epc;
    logic              bp_fail;
    logic [31:0]       pc_not_taken;
    logic              pred_taken;
    logic [31:0]       pred_target;
    logic              queue_full;
    logic              out_valid;
    logic [31:0]       out_pc;
    logic [32*c_FW-1:0] out_data;
    logic [c_FW-1:0]   out_mask;
    logic              out_adel;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]       perf_killed;
    logic [31:0]       perf_stall;
`endif

    fetch_pc_gen #(
        .FETCH_WIDTH     (c_FW),
        .MAX_OUTSTANDING (2),
        .RESET_PC        (32'hbfc00000)
    ) u_dut (
        .clk           (clk),
        .resetn        (resetn),
        .ireq_valid    (ireq_valid),
        .ireq_addr     (ireq_addr),
        .ireq_addr_ok  (ireq_addr_ok),
        .iresp_data_ok (iresp_data_ok),
        .iresp_data    (iresp_data),
        .exc_valid     (exc_valid),
        .exc_vec       (exc_vec),
        .eret          (eret),
        .epc           (epc),
        .bp_fail       (bp_fail),
        .pc_not_taken  (pc_not_taken),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .queue_full    (queue_full),
        .out_valid     (out_valid),
        .out_pc        (out_pc),
        .out_data      (out_data),
        .out_mask      (out_mask),
        .out_adel      (out_adel)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_killed   (perf_killed),
        .perf_stall    (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_errors;
    int          vld_cnt;
    logic        r_last_vld;
    logic        resp_en;
    logic [31:0] bq [$];
    logic [31:0] acc_q [$];
    logic [31:0] opc_q [$];
    logic [63:0] odata_q [$];
    logic [1:0]  omask_q [$];
    logic        oadel_q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mkdata(input logic [31:0] a);
        return {a + 32'd4, a};
    endfunction

    task automatic clear_logs();
        acc_q.delete();
        opc_q.delete();
        odata_q.delete();
        omask_q.delete();
        oadel_q.delete();
        vld_cnt = 0;
    endtask

    // One clock: drive bus response, sample pre-edge handshakes, log post-edge outputs.
    task automatic step();
        logic        acc;
        logic        rsp;
        logic [31:0] acc_addr;
        iresp_data_ok = resp_en && (bq.size() > 0);
        iresp_data    = iresp_data_ok ? mkdata(bq[0]) : '0;
        #1;
        acc        = ireq_valid && ireq_addr_ok;
        acc_addr   = ireq_addr;
        rsp        = iresp_data_ok;
        r_last_vld = ireq_valid;
        if (ireq_valid) vld_cnt++;
        @(posedge clk);
        if (rsp) void'(bq.pop_front());
        if (acc) begin
            bq.push_back(acc_addr);
            acc_q.push_back(acc_addr);
        end
        #1;
        if (out_valid) begin
            opc_q.push_back(out_pc);
            odata_q.push_back(out_data);
            omask_q.push_back(out_mask);
            oadel_q.push_back(out_adel);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        ireq_addr_ok = 1'b0;
        resp_en      = 1'b1;
        for (int i = 0; i < 20 && bq.size() > 0; i++) step();
        chk("drain_left", 64'(bq.size()), 64'd0);
        step();
    endtask

    task automatic do_reset();
        resetn = 1'b0; ireq_addr_ok = 1'b0; iresp_data_ok = 1'b0; iresp_data = '0;
        exc_valid = 1'b0; exc_vec = '0; eret = 1'b0; epc = '0;
        bp_fail = 1'b0; pc_not_taken = '0; pred_taken = 1'b0; pred_target = '0;
        queue_full = 1'b0; resp_en = 1'b0;
        bq.delete();
        step();
        step();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        r_last_vld = 1'b0;
        clear_logs();

        // Reset state
        do_reset();
        chk("rst_ireq_valid", 64'(ireq_valid), 64'd0);
        chk("rst_ireq_addr",  64'(ireq_addr),  64'hbfc00000);
        chk("rst_out_valid",  64'(out_valid),  64'd0);
        chk("rst_out_pc",     64'(out_pc),     64'd0);
        chk("rst_out_mask",   64'(out_mask),   64'd0);
        chk("rst_out_adel",   64'(out_adel),   64'd0);
        resetn = 1'b1;

        // Sequential fetch, handshakes always accepted
        clear_logs();
        ireq_addr_ok = 1'b1; resp_en = 1'b1;
        repeat (3) step();
        drain();
        chk("seq_acc0",  64'(acc_q[0]), 64'hbfc00000);
        chk("seq_acc1",  64'(acc_q[1]), 64'hbfc00008);
        chk("seq_acc2",  64'(acc_q[2]), 64'hbfc00010);
        chk("seq_nout",  64'(opc_q.size()), 64'd3);
        chk("seq_pc0",   64'(opc_q[0]), 64'hbfc00000);
        chk("seq_data0", odata_q[0], 64'hbfc00004_bfc00000);
        chk("seq_mask0", 64'(omask_q[0]), 64'd3);
        chk("seq_mask1", 64'(omask_q[1]), 64'd3);
        chk("seq_mask2", 64'(omask_q[2]), 64'd3);

        // Redirect kills two in-flight requests
        do_reset();
        resetn = 1'b1;
        ireq_addr_ok = 1'b1; resp_en = 1'b0;
        step();
        step();
        step();
        chk("kill_full_vld", 64'(r_last_vld), 64'd0);
        clear_logs();
        bp_fail = 1'b1; pc_not_taken = 32'hbfc00104;
        step();
        chk("kill_redir_vld", 64'(r_last_vld), 64'd0);
        bp_fail = 1'b0; resp_en = 1'b1;
        repeat (3) step();
        drain();
        chk("kill_acc0",  64'(acc_q[0]), 64'hbfc00100);
        chk("kill_nout",  64'(opc_q.size()), 64'd2);
        chk("kill_pc0",   64'(opc_q[0]), 64'hbfc00100);
        chk("kill_mask0", 64'(omask_q[0]), 64'd2);
        chk("kill_data0", odata_q[0], 64'hbfc00104_bfc00100);
        chk("kill_pc1",   64'(opc_q[1]), 64'hbfc00108);

        // Priority: exception beats eret and mispredict
        exc_valid = 1'b1; exc_vec = 32'hbfc00380;
        eret = 1'b1; epc = 32'hbfc00500;
        bp_fail = 1'b1; pc_not_taken = 32'hbfc00600;
        step();
        exc_valid = 1'b0; eret = 1'b0; bp_fail = 1'b0;
        clear_logs();
        ireq_addr_ok = 1'b1;
        step();
        drain();
        chk("prio_acc0", 64'(acc_q[0]), 64'hbfc00380);

        // Issue throttle via queue_full
        clear_logs();
        ireq_addr_ok = 1'b1; resp_en = 1'b1;
        step();
        chk("thr_acc0", 64'(acc_q[0]), 64'hbfc00388);
        queue_full = 1'b1;
        clear_logs();
        repeat (5) step();
        chk("thr_vld_cnt", 64'(vld_cnt), 64'd0);
        chk("thr_nout",    64'(opc_q.size()), 64'd1);
        chk("thr_pc0",     64'(opc_q[0]), 64'hbfc00388);
        queue_full = 1'b0;
        clear_logs();
        step();
        chk("thr_resume_vld", 64'(r_last_vld), 64'd1);
        chk("thr_resume_acc", 64'(acc_q[0]), 64'hbfc00390);
        drain();

        // Misaligned eret target
        clear_logs();
        eret = 1'b1; epc = 32'h80000002;
        step();
        eret = 1'b0;
        ireq_addr_ok = 1'b1;
        repeat (5) step();
        chk("adel_nacc",  64'(acc_q.size()), 64'd0);
        chk("adel_vld",   64'(vld_cnt), 64'd0);
        chk("adel_nout",  64'(opc_q.size()), 64'd1);
        chk("adel_flag",  64'(oadel_q[0]), 64'd1);
        chk("adel_pc",    64'(opc_q[0]), 64'h80000002);
        chk("adel_mask",  64'(omask_q[0]), 64'd0);
        clear_logs();
        exc_valid = 1'b1; exc_vec = 32'hbfc00380;
        step();
        exc_valid = 1'b0;
        step();
        chk("adel_exit_acc", 64'(acc_q[0]), 64'hbfc00380);
        drain();

        // Response coincides with redirect, one outstanding
        clear_logs();
        ireq_addr_ok = 1'b1; resp_en = 1'b0;
        step();
        chk("rr_acc0", 64'(acc_q[0]), 64'hbfc00388);
        ireq_addr_ok = 1'b0;
        bp_fail = 1'b1; pc_not_taken = 32'hbfc00200; resp_en = 1'b1;
        step();
        bp_fail = 1'b0;
        ireq_addr_ok = 1'b1;
        step();
        step();
        drain();
        chk("rr_nout",  64'(opc_q.size()), 64'd2);
        chk("rr_pc0",   64'(opc_q[0]), 64'hbfc00200);
        chk("rr_mask0", 64'(omask_q[0]), 64'd3);

        // Predicted-taken replaces the sequential PC without killing
        clear_logs();
        ireq_addr_ok = 1'b1; resp_en = 1'b1;
        pred_taken = 1'b1; pred_target = 32'hbfc00404;
        step();
        pred_taken = 1'b0;
        step();
        step();
        drain();
        chk("pred_acc0",  64'(acc_q[0]), 64'hbfc00210);
        chk("pred_acc1",  64'(acc_q[1]), 64'hbfc00400);
        chk("pred_acc2",  64'(acc_q[2]), 64'hbfc00408);
        chk("pred_pc0",   64'(opc_q[0]), 64'hbfc00210);
        chk("pred_pc1",   64'(opc_q[1]), 64'hbfc00400);
        chk("pred_mask1", 64'(omask_q[1]), 64'd2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
